sipo_deserializer: RTL
======================

Name: sipo_deserializer

Overview:
- Serial-in/parallel-out receiver; sits directly downstream of the team's parallel-load shift-out register.
- Consumes that register's MSB-first serial stream, one bit per strobe, and reassembles WIDTH-bit words.
- Presents each word on a held parallel output with a valid/ack handshake to the consuming logic.
- Flags frame restarts and overruns.

Parameters:
- WIDTH, 4, bits per word. Must be at least 2. Default matches the upstream 4-bit shifter.

Ports:
- clk  input  1  system clock; all state updates on its rising edge.
- reset  input  1  synchronous, active-low reset. reset=0 at a rising clk edge clears all state.
- si  input  1  serial data bit, MSB of the word first.
- shift  input  1  bit strobe; si is sampled on edges where shift=1.
- start  input  1  frame start marker; asserted on the cycle of the first bit or any cycle before it.
- ack  input  1  consumer has taken po; only meaningful while valid=1.
- clr_ovr  input  1  clears the overrun flag.
- po  output  WIDTH  last completed word; held stable between updates.
- valid  output  1  po holds an unacknowledged word.
- busy  output  1  frame in progress (state RECV).
- bit_cnt  output  clog2(WIDTH+1)  bits captured in the current frame.
- overrun  output  1  sticky: a completed word was dropped.
- frame_err  output  1  one-cycle pulse when start aborts a frame in progress.

Behaviour:
- Reset (reset=0 at an edge): state=IDLE, shift register=0, bit_cnt=0, po=0, valid=0, busy=0, overrun=0, frame_err=0. Reset dominates every other input, including mid-frame; a partial word is discarded.
- State machine: two states, IDLE and RECV. busy=1 exactly when state=RECV.
- IDLE:
  - shift is ignored unless start=1.
  - start=1, shift=0: go to RECV, shift register=0, bit_cnt=0.
  - start=1, shift=1: go to RECV, shift register={0..0,si}, bit_cnt=1.
- RECV, shift=1:
  - shift register <= {sr[WIDTH-2:0], si}; bit_cnt increments.
  - First bit received ends up in po[WIDTH-1] (MSB first).
  - shift=0 cycles are gaps; nothing changes. Gaps of any length are allowed.
- Completion: on the edge that captures bit number WIDTH:
  - the assembled word (including that bit) is offered to po;
  - state goes to IDLE, bit_cnt=0.
  - Latency: valid and po update on that same edge, visible the cycle after the last strobe cycle.
- Offer rules at completion:
  - valid=0, or valid=1 with ack=1 in the same cycle: po <= word, valid <= 1.
  - valid=1 with ack=0: word dropped, po unchanged, valid stays 1, overrun <= 1.
- Handshake:
  - With valid=1 and ack=1 and no completion that cycle, valid <= 0 at the edge.
  - ack while valid=0 has no effect.
  - po never changes while valid=1 except via a same-cycle ack and completion.
- start while in RECV (abort/restart):
  - frame_err pulses for one cycle.
  - The partial word is discarded and RECV restarts exactly as start does from IDLE, including same-cycle capture when shift=1.
  - If that same cycle would have completed a word, start wins: no completion, no valid.
- overrun: cleared only by clr_ovr=1 or reset. If clr_ovr=1 and a new overrun occur in the same cycle, overrun stays 1 (set wins).
- Width rules: bit_cnt never exceeds WIDTH and wraps to 0 on completion. po is exactly WIDTH bits; no sign or extension handling.

Test Plan:
- Reset: hold reset=0 for 2 edges with start=1, shift=1, si=1 -> po=0, valid=0, busy=0, bit_cnt=0, overrun=0, frame_err=0.
- Back-to-back word (WIDTH=4): start+shift with si=1, then shift with si=0,1,1 on consecutive cycles -> valid=1 and po=4'b1011 the cycle after the 4th strobe; both held until ack=1, then valid=0 the next cycle.
- Gapped strobes: start alone, then si=0,1,1,0 with 3 idle cycles between each strobe -> busy=1 throughout, bit_cnt steps 1..3, po=4'b0110, valid=1.
- Overrun: receive 1111 with no ack, then receive 0001 -> po stays 4'b1111, valid=1, overrun=1. Ack -> valid=0, overrun still 1. clr_ovr=1 -> overrun=0. Repeat with ack asserted on the completion cycle -> po=4'b0001, valid stays 1, no overrun.
- Restart: after 2 bits (1,1), assert start with shift=1, si=1, then send 0,0,1 -> frame_err=1 for exactly one cycle, po=4'b1001.
- Mid-frame reset: after 3 bits, reset=0 for one edge -> busy=0, bit_cnt=0, valid=0. Next full frame 0101 -> po=4'b0101, valid=1.

Source files
------------

// File: rtl/sipo_deserializer_if.sv
// sipo_deserializer_if
//   Bundles the serial input, the consumer handshake and the status outputs
//   of sipo_deserializer. clk and reset stay outside as plain ports.
//   master : the side that drives serial data, strobes and ack.
//   slave  : the deserializer itself.
//   Signals:
//     si, shift, start    serial bit, bit strobe, frame start marker
//     ack, clr_ovr        consumer took po / clear sticky overrun
//     po, valid           held parallel word and its "unacknowledged" flag
//     busy, bit_cnt       frame in progress / bits captured so far
//     overrun, frame_err  sticky dropped-word flag / one-cycle abort pulse
//     state_dbg           raw FSM state (0=IDLE, 1=RECV) for checkers
interface sipo_deserializer_if #(
  parameter int WIDTH = 4
);
  localparam int CW = $clog2(WIDTH + 1);

  logic             si;
  logic             shift;
  logic             start;
  logic             ack;
  logic             clr_ovr;
  logic [WIDTH-1:0] po;
  logic             valid;
  logic             busy;
  logic [CW-1:0]    bit_cnt;
  logic             overrun;
  logic             frame_err;
  logic             state_dbg;

  modport master (
    output si, shift, start, ack, clr_ovr,
    input  po, valid, busy, bit_cnt, overrun, frame_err, state_dbg
  );

  modport slave (
    input  si, shift, start, ack, clr_ovr,
    output po, valid, busy, bit_cnt, overrun, frame_err, state_dbg
  );
endinterface

// File: rtl/sipo_deserializer.sv
// sipo_deserializer
//   Serial-in/parallel-out receiver for an MSB-first stream, one bit per
//   shift strobe. Each WIDTH-bit word is presented on a held output po with
//   a valid/ack handshake. Frame restarts (start while receiving) pulse
//   frame_err; words completed while the previous one is still
//   unacknowledged are dropped and set the sticky overrun flag.
//   Ports:
//     clk    rising-edge system clock
//     reset  synchronous, active-low; clears all state
//     bus    sipo_deserializer_if.slave (see the interface for signals)
//
//   Handshake: valid=1 means po holds a word not yet taken. The consumer
//   takes it by raising ack while valid=1; valid drops at that edge unless a
//   new word completes in the same cycle, in which case po is replaced and
//   valid stays high. ack while valid=0 is ignored. po only changes when a
//   word is accepted.
module sipo_deserializer #(
  parameter int WIDTH = 4
) (
  input  logic               clk,
  input  logic               reset,
  sipo_deserializer_if.slave bus
);
  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST_IDX = CW'(WIDTH - 1);

  typedef enum logic {
    IDLE = 1'b0,
    RECV = 1'b1
  } state_t;

  state_t           state_q, state_d;
  // Only WIDTH-1 bits need storing: the final bit of a word comes straight
  // from si on the completing edge.
  logic [WIDTH-2:0] sr_q, sr_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] po_q, po_d;
  logic             valid_q, valid_d;
  logic             ovr_q, ovr_d;
  logic             ferr_q, ferr_d;

  logic [WIDTH-1:0] word;
  logic             complete;
  logic             ovr_set;

  always_comb begin
    state_d  = state_q;
    sr_d     = sr_q;
    cnt_d    = cnt_q;
    po_d     = po_q;
    valid_d  = valid_q;
    ferr_d   = 1'b0;
    complete = 1'b0;
    ovr_set  = 1'b0;
    word     = {sr_q, bus.si};

    // start has priority over everything in the frame path, including a
    // bit that would otherwise complete the current word.
    if (bus.start) begin
      ferr_d  = (state_q == RECV);
      state_d = RECV;
      sr_d    = '0;
      cnt_d   = '0;
      if (bus.shift) begin
        sr_d[0] = bus.si;
        cnt_d   = CW'(1);
      end
    end else if (state_q == RECV && bus.shift) begin
      if (cnt_q == LAST_IDX) begin
        complete = 1'b1;
        state_d  = IDLE;
        sr_d     = '0;
        cnt_d    = '0;
      end else begin
        sr_d  = word[WIDTH-2:0];
        cnt_d = cnt_q + 1'b1;
      end
    end

    if (complete) begin
      if (!valid_q || bus.ack) begin
        po_d    = word;
        valid_d = 1'b1;
      end else begin
        ovr_set = 1'b1;
      end
    end else if (valid_q && bus.ack) begin
      valid_d = 1'b0;
    end

    // A new overrun beats a same-cycle clear.
    ovr_d = ovr_set | (ovr_q & ~bus.clr_ovr);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= IDLE;
      sr_q    <= '0;
      cnt_q   <= '0;
      po_q    <= '0;
      valid_q <= 1'b0;
      ovr_q   <= 1'b0;
      ferr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sr_q    <= sr_d;
      cnt_q   <= cnt_d;
      po_q    <= po_d;
      valid_q <= valid_d;
      ovr_q   <= ovr_d;
      ferr_q  <= ferr_d;
    end
  end

  assign bus.po        = po_q;
  assign bus.valid     = valid_q;
  assign bus.busy      = (state_q == RECV);
  assign bus.bit_cnt   = cnt_q;
  assign bus.overrun   = ovr_q;
  assign bus.frame_err = ferr_q;
  assign bus.state_dbg = state_q;
endmodule
